// File: rtl/lector_arbitro_if.sv
// Bundle between the four output FIFOs, the link-state source and the downstream consumer.
// Carries no logic; the slave modport is the arbiter's view of the signals.
// The master modport is the environment's view: it drives the FIFO side and consumes data_out.
interface lector_arbitro_if #(
   parameter int DATA_W = 6
);
   logic [3:0]        state;
   logic              empty0_morado;
   logic              empty1_morado;
   logic              empty2_morado;
   logic              empty3_morado;
   logic [DATA_W-1:0] data0_morado;
   logic [DATA_W-1:0] data1_morado;
   logic [DATA_W-1:0] data2_morado;
   logic [DATA_W-1:0] data3_morado;
   logic              pop0;
   logic              pop1;
   logic              pop2;
   logic              pop3;
   logic              ready_in;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic [1:0]        src_out;
   logic              idle_out;

   modport slave (
      input  state, empty0_morado, empty1_morado, empty2_morado, empty3_morado,
      input  data0_morado, data1_morado, data2_morado, data3_morado, ready_in,
      output pop0, pop1, pop2, pop3, data_out, valid_out, src_out, idle_out
   );

   modport master (
      output state, empty0_morado, empty1_morado, empty2_morado, empty3_morado,
      output data0_morado, data1_morado, data2_morado, data3_morado, ready_in,
      input  pop0, pop1, pop2, pop3, data_out, valid_out, src_out, idle_out
   );
endinterface

// File: rtl/lector_arbitro.sv
// Round-robin reader that drains four FWFT output FIFOs into one registered output word.
// Latency: pop to valid_out is 1 cycle; one word per cycle when the consumer keeps ready_in high.
// Backpressure: with valid_out high and ready_in low nothing is popped and the held word stays put.
// Optional: define LECTOR_ARBITRO_CONTADORES_EN to add saturating per-FIFO pop counters cnt0..cnt3.
module lector_arbitro #(
   parameter int         DATA_W    = 6,
   parameter logic [3:0] ACTIVE_ST = 4'b1000
) (
   input  logic                 clk,
   input  logic                 reset_L,
   lector_arbitro_if.slave      bus
`ifdef LECTOR_ARBITRO_CONTADORES_EN
   ,
   output logic [4:0]           cnt0,
   output logic [4:0]           cnt1,
   output logic [4:0]           cnt2,
   output logic [4:0]           cnt3
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_STALL = 2'd2
   } fsm_t;

   fsm_t              fsm_q, fsm_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        src_q, src_d;
   logic [1:0]        ptr_q, ptr_d;

   logic [3:0]        cand;
   logic [DATA_W-1:0] head [4];
   logic              valid;
   logic              slot_free;
   logic              active;
   logic              found;
   logic [1:0]        grant;
   logic              pop_any;
   logic [3:0]        pop_vec;

   assign cand    = {~bus.empty3_morado, ~bus.empty2_morado, ~bus.empty1_morado, ~bus.empty0_morado};
   assign head[0] = bus.data0_morado;
   assign head[1] = bus.data1_morado;
   assign head[2] = bus.data2_morado;
   assign head[3] = bus.data3_morado;

   // valid_out is simply "the FSM holds a word"
   assign valid     = (fsm_q != ST_IDLE);
   assign slot_free = !valid || bus.ready_in;
   assign active    = (bus.state == ACTIVE_ST);

   // Round-robin search starting one past the last granted FIFO
   always_comb begin
      grant = ptr_q;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         logic [1:0] idx;
         idx = ptr_q + 2'(k);
         if (!found && cand[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   // reset_L gates the strobes so no FIFO loses a word while the block is held in reset
   assign pop_any = reset_L && active && slot_free && found;
   assign pop_vec = pop_any ? (4'b0001 << grant) : 4'b0000;

   assign bus.pop0      = pop_vec[0];
   assign bus.pop1      = pop_vec[1];
   assign bus.pop2      = pop_vec[2];
   assign bus.pop3      = pop_vec[3];
   assign bus.data_out  = data_q;
   assign bus.src_out   = src_q;
   assign bus.valid_out = valid;
   assign bus.idle_out  = (&(~cand)) && !valid;

   // Next-state: a pop loads the slot, otherwise a transfer empties it, otherwise hold
   always_comb begin
      fsm_d  = fsm_q;
      data_d = data_q;
      src_d  = src_q;
      ptr_d  = ptr_q;
      if (pop_any) begin
         data_d = head[grant];
         src_d  = grant;
         ptr_d  = grant;
         fsm_d  = ST_SERVE;
      end else begin
         case (fsm_q)
            ST_SERVE: fsm_d = bus.ready_in ? ST_IDLE : ST_STALL;
            ST_STALL: fsm_d = bus.ready_in ? ST_IDLE : ST_STALL;
            default:  fsm_d = ST_IDLE;
         endcase
      end
   end

   // Output slot, source index, round-robin pointer and FSM registers
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         fsm_q  <= ST_IDLE;
         data_q <= '0;
         src_q  <= 2'd0;
         ptr_q  <= 2'd3;
      end else begin
         fsm_q  <= fsm_d;
         data_q <= data_d;
         src_q  <= src_d;
         ptr_q  <= ptr_d;
      end
   end

`ifdef LECTOR_ARBITRO_CONTADORES_EN
   logic [4:0] cnt_q [4];
   logic [4:0] cnt_d [4];

   // Per-FIFO pop counters that stick at 31
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (pop_vec[i] && (cnt_q[i] != 5'd31)) begin
            cnt_d[i] = cnt_q[i] + 5'd1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= 5'd0;
      end else begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign cnt0 = cnt_q[0];
   assign cnt1 = cnt_q[1];
   assign cnt2 = cnt_q[2];
   assign cnt3 = cnt_q[3];
`endif

endmodule
